// File: rtl/drfm_pkg.sv
// Shared constants for the DRFM sample buffer: SDRAM geometry, ring placement
// and the arbiter state encoding used by the SDRAM and PWM blocks.
package drfm_pkg;

    localparam int DRFM_ADDR_W     = 24;
    localparam int DRFM_DATA_W     = 16;
    localparam int DRFM_BUF_WORDS  = 1048576;
    localparam int DRFM_BASE_ADDR  = 0;
    localparam int DRFM_STARVE_MAX = 64;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_WAIT_RD = 2'd2
    } arb_state_e;

    // Counter/pointer width for a modulus of 'words'; never narrower than one bit.
    function automatic int ptr_width(input int words);
        return (words <= 2) ? 1 : $clog2(words);
    endfunction

endpackage

// File: rtl/sdram_req_arbiter_sample_ring_ptrs.sv
// Circular sample buffer bookkeeping: write/read pointers that wrap modulo
// BUF_WORDS and a non-wrapping fill level with full/empty flags.
module sample_ring_ptrs
    import drfm_pkg::*;
#(
    parameter int ADDR_W    = DRFM_ADDR_W,
    parameter int BUF_WORDS = DRFM_BUF_WORDS,
    parameter int PTR_W     = ptr_width(DRFM_BUF_WORDS)
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             wr_inc,
    input  logic             rd_inc,
    output logic [PTR_W-1:0] wr_ptr,
    output logic [PTR_W-1:0] rd_ptr,
    output logic [ADDR_W:0]  level,
    output logic             full,
    output logic             empty
);

    localparam int LEVEL_W = ADDR_W + 1;

    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_d;
    logic [LEVEL_W-1:0] level_q;
    logic [LEVEL_W-1:0] level_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (wr_inc) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (rd_inc) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        // Only one transaction is in flight, but a simultaneous inc/dec still nets to zero.
        if (wr_inc && !rd_inc) begin
            level_d = level_q + LEVEL_W'(1);
        end else if (rd_inc && !wr_inc) begin
            level_d = level_q - LEVEL_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    assign wr_ptr = wr_ptr_q;
    assign rd_ptr = rd_ptr_q;
    assign level  = level_q;
    assign full   = (level_q == LEVEL_W'(BUF_WORDS));
    assign empty  = (level_q == '0);

endmodule

// File: rtl/sdram_req_arbiter.sv
// Shares the single SDRAM controller port between capture writes and PWM
// playback reads, one transaction at a time, over a circular sample buffer.
module sdram_req_arbiter
    import drfm_pkg::*;
#(
    parameter int ADDR_W     = DRFM_ADDR_W,
    parameter int DATA_W     = DRFM_DATA_W,
    parameter int BUF_WORDS  = DRFM_BUF_WORDS,
    parameter int BASE_ADDR  = DRFM_BASE_ADDR,
    parameter int STARVE_MAX = DRFM_STARVE_MAX
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              cap_en,
    input  logic              pb_en,
    input  logic              cap_valid,
    input  logic [DATA_W-1:0] cap_data,
    output logic              cap_ready,
    input  logic              pb_req,
    output logic [DATA_W-1:0] pb_data,
    output logic              pb_valid,
    output logic              ctl_req,
    output logic              ctl_we,
    output logic [ADDR_W-1:0] ctl_addr,
    output logic [DATA_W-1:0] ctl_wdata,
    input  logic              ctl_ack,
    input  logic              ctl_rvalid,
    input  logic [DATA_W-1:0] ctl_rdata,
    output logic [ADDR_W:0]   level,
    output logic              underrun,
    output logic              overrun,
    output logic              late
);

    localparam int PTR_W = ptr_width(BUF_WORDS);
    localparam int CNT_W = ptr_width(STARVE_MAX + 1);

    arb_state_e        state_q;
    arb_state_e        state_d;
    logic              rd_pend_q;
    logic              rd_pend_d;
    logic              stg_full_q;
    logic              stg_full_d;
    logic [DATA_W-1:0] stg_data_q;
    logic [DATA_W-1:0] stg_data_d;
    logic [CNT_W-1:0]  starve_q;
    logic [CNT_W-1:0]  starve_d;
    logic              ctl_we_q;
    logic              ctl_we_d;
    logic [ADDR_W-1:0] ctl_addr_q;
    logic [ADDR_W-1:0] ctl_addr_d;
    logic [DATA_W-1:0] ctl_wdata_q;
    logic [DATA_W-1:0] ctl_wdata_d;
    logic [DATA_W-1:0] pb_data_q;
    logic [DATA_W-1:0] pb_data_d;
    logic              pb_valid_q;
    logic              pb_valid_d;
    logic              underrun_q;
    logic              underrun_d;
    logic              overrun_q;
    logic              overrun_d;
    logic              late_q;
    logic              late_d;

    logic              wr_done;
    logic              rd_done;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [ADDR_W:0]   level_w;
    logic              full;
    logic              empty;

    logic              cap_fire;
    logic              pb_fire;
    logic              starved;
    logic              rd_win;
    logic              wr_win;

    sample_ring_ptrs #(
        .ADDR_W    (ADDR_W),
        .BUF_WORDS (BUF_WORDS),
        .PTR_W     (PTR_W)
    ) u_ring (
        .CLK    (CLK),
        .reset  (reset),
        .wr_inc (wr_done),
        .rd_inc (rd_done),
        .wr_ptr (wr_ptr),
        .rd_ptr (rd_ptr),
        .level  (level_w),
        .full   (full),
        .empty  (empty)
    );

    // Staging must be empty, so level+staged < BUF_WORDS reduces to !full.
    assign cap_ready = cap_en && !stg_full_q && !full && !reset;
    assign cap_fire  = cap_valid && cap_ready;
    assign pb_fire   = pb_req && pb_en;

    // Reads win by default; a write that has waited STARVE_MAX cycles takes the next slot.
    assign starved = stg_full_q && (starve_q == CNT_W'(STARVE_MAX));
    assign rd_win  = rd_pend_q && !empty && !starved;
    assign wr_win  = !rd_win && stg_full_q;

    always_comb begin
        state_d     = state_q;
        rd_pend_d   = rd_pend_q;
        stg_full_d  = stg_full_q;
        stg_data_d  = stg_data_q;
        starve_d    = starve_q;
        ctl_we_d    = ctl_we_q;
        ctl_addr_d  = ctl_addr_q;
        ctl_wdata_d = ctl_wdata_q;
        pb_data_d   = pb_data_q;
        pb_valid_d  = 1'b0;
        underrun_d  = underrun_q;
        overrun_d   = overrun_q;
        late_d      = late_q;
        wr_done     = 1'b0;
        rd_done     = 1'b0;

        if (cap_en && cap_valid && full) begin
            overrun_d = 1'b1;
        end
        if (cap_fire) begin
            stg_full_d = 1'b1;
            stg_data_d = cap_data;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (rd_win) begin
                    state_d    = ST_REQ;
                    ctl_we_d   = 1'b0;
                    ctl_addr_d = ADDR_W'(BASE_ADDR) + ADDR_W'(rd_ptr);
                    rd_pend_d  = 1'b0;
                end else if (wr_win) begin
                    state_d     = ST_REQ;
                    ctl_we_d    = 1'b1;
                    ctl_addr_d  = ADDR_W'(BASE_ADDR) + ADDR_W'(wr_ptr);
                    ctl_wdata_d = stg_data_q;
                end
                // Underrun needs no bus slot, so it resolves alongside any write grant.
                if (rd_pend_q && empty) begin
                    underrun_d = 1'b1;
                    rd_pend_d  = 1'b0;
                    pb_valid_d = 1'b1;
                end
            end
            ST_REQ: begin
                if (ctl_ack) begin
                    if (ctl_we_q) begin
                        wr_done    = 1'b1;
                        stg_full_d = 1'b0;
                        state_d    = ST_IDLE;
                    end else begin
                        state_d = ST_WAIT_RD;
                    end
                end
            end
            ST_WAIT_RD: begin
                if (ctl_rvalid) begin
                    pb_data_d  = ctl_rdata;
                    pb_valid_d = 1'b1;
                    rd_done    = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A repeat request while one is still pending is merged into it.
        if (pb_fire) begin
            if (rd_pend_q) begin
                late_d = 1'b1;
            end else begin
                rd_pend_d = 1'b1;
            end
        end

        if (state_q == ST_IDLE && wr_win) begin
            starve_d = '0;
        end else if (stg_full_q && !(state_q == ST_REQ && ctl_we_q) && !starved) begin
            starve_d = starve_q + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            rd_pend_q   <= 1'b0;
            stg_full_q  <= 1'b0;
            stg_data_q  <= '0;
            starve_q    <= '0;
            ctl_we_q    <= 1'b0;
            ctl_addr_q  <= '0;
            ctl_wdata_q <= '0;
            pb_data_q   <= '0;
            pb_valid_q  <= 1'b0;
            underrun_q  <= 1'b0;
            overrun_q   <= 1'b0;
            late_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_pend_q   <= rd_pend_d;
            stg_full_q  <= stg_full_d;
            stg_data_q  <= stg_data_d;
            starve_q    <= starve_d;
            ctl_we_q    <= ctl_we_d;
            ctl_addr_q  <= ctl_addr_d;
            ctl_wdata_q <= ctl_wdata_d;
            pb_data_q   <= pb_data_d;
            pb_valid_q  <= pb_valid_d;
            underrun_q  <= underrun_d;
            overrun_q   <= overrun_d;
            late_q      <= late_d;
        end
    end

    assign ctl_req   = (state_q == ST_REQ) && !reset;
    assign ctl_we    = ctl_we_q;
    assign ctl_addr  = ctl_addr_q;
    assign ctl_wdata = ctl_wdata_q;
    assign pb_data   = pb_data_q;
    assign pb_valid  = pb_valid_q;
    assign level     = level_w;
    assign underrun  = underrun_q;
    assign overrun   = overrun_q;
    assign late      = late_q;

endmodule
